// File: rtl/tpu_buf_pkg.sv
// Shared definitions for the systolic-array input skew buffer.
//   DEFAULT_DATA_WIDTH : default element width for the buffer and its lane FIFOs
//   fsm_state_t        : drain controller states
package tpu_buf_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/skew_lane_fifo.sv
// Single-lane circular FIFO used by input_skew_buffer.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   wr_en_i, wr_data_i     write strobe / data (ignored when full)
//   rd_en_i                read strobe, advances the read pointer
//   rd_last_i              marks the final read of a drain
//   replay_i               1 = reads leave the count untouched and the read
//                          pointer returns to the snapshot on the last read
//   snap_en_i              capture the current read pointer
//   rd_data_o              entry at the read pointer (combinational)
//   count_o, full_o, empty_o  occupancy
module skew_lane_fifo
    import tpu_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 8,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  rd_last_i,
    input  logic                  replay_i,
    input  logic                  snap_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      snap_q, snap_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_ok;
    logic                  dec;

    assign wr_ok = wr_en_i && !full_o;
    assign dec   = rd_en_i && !replay_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        snap_d   = snap_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        // Replay rewinds to where the drain began once the last row is out.
        if (rd_en_i) rd_ptr_d = (replay_i && rd_last_i) ? snap_q : rd_ptr_q + PTR_W'(1);
        if (snap_en_i) snap_d = rd_ptr_q;
        if (wr_ok && !dec)      count_d = count_q + CNT_W'(1);
        else if (!wr_ok && dec) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            snap_q   <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            snap_q   <= snap_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/input_skew_buffer.sv
// Multi-lane input staging buffer feeding the left edge of the systolic array.
// Each lane is a skew_lane_fifo; a drain emits N rows with lane i lagging lane 0
// by i cycles. Replay keeps the data for reuse across weight tiles.
// Ports:
//   clk, rst                                 clock, asynchronous active-low reset
//   wr_valid_in/wr_lane_in/wr_data_in        host write, wr_ready_out back-pressure
//   nn_valid_in/nn_lane_in/nn_data_in        NN write-back, wins over the host
//   drain_start_in/drain_count_in/replay_in  drain command (sampled in IDLE)
//   data_out/valid_out                       registered skewed rows, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy_out/done_out/err_out                status; err_out is sticky
//   lane_full_out/lane_empty_out             per-lane occupancy flags
//
// state | meaning
// IDLE  | accepting drain commands
// DRAIN | issuing one lane-0 read strobe per cycle, N cycles
// FLUSH | NUM_LANES-1 cycles letting the skew register empty
module input_skew_buffer
    import tpu_buf_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_LANES  = 4,
    parameter  int DEPTH      = 8,
    localparam int LANE_W     = $clog2(NUM_LANES),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid_in,
    input  logic [LANE_W-1:0]               wr_lane_in,
    input  logic signed [DATA_WIDTH-1:0]    wr_data_in,
    output logic                            wr_ready_out,
    input  logic                            nn_valid_in,
    input  logic [LANE_W-1:0]               nn_lane_in,
    input  logic signed [DATA_WIDTH-1:0]    nn_data_in,
    input  logic                            drain_start_in,
    input  logic [CNT_W-1:0]                drain_count_in,
    input  logic                            replay_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]            valid_out,
    output logic                            busy_out,
    output logic                            done_out,
    output logic [NUM_LANES-1:0]            lane_full_out,
    output logic [NUM_LANES-1:0]            lane_empty_out,
    output logic                            err_out
);

    fsm_state_t                      state_q, state_d;
    logic [CNT_W-1:0]                rem_q, rem_d;
    logic [LANE_W-1:0]               flush_q, flush_d;
    logic                            replay_q, replay_d;
    logic [NUM_LANES-2:0]            skew_stb_q, skew_last_q;
    logic [NUM_LANES-1:0]            rd_stb, rd_last;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]            valid_q;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic [NUM_LANES-1:0]            wr_en, full, empty;
    logic [CNT_W-1:0]                lane_cnt [NUM_LANES];
    logic [DATA_WIDTH-1:0]           lane_rd  [NUM_LANES];
    logic signed [DATA_WIDTH-1:0]    wr_data;
    logic                            snap_en, drain_ok, wr_err;

    // Lane 0 reads straight from the FSM; lane i reads from skew stage i-1.
    assign rd_stb  = {skew_stb_q,  state_q == DRAIN};
    assign rd_last = {skew_last_q, (state_q == DRAIN) && (rem_q == CNT_W'(1))};

    assign wr_ready_out = !nn_valid_in && !full[wr_lane_in];
    assign wr_data      = nn_valid_in ? nn_data_in : wr_data_in;

    always_comb begin
        wr_en  = '0;
        wr_err = 1'b0;
        if (nn_valid_in) begin
            if (full[nn_lane_in]) wr_err = 1'b1;
            else                  wr_en[nn_lane_in] = 1'b1;
        end else if (wr_valid_in) begin
            if (full[wr_lane_in]) wr_err = 1'b1;
            else                  wr_en[wr_lane_in] = 1'b1;
        end
    end

    always_comb begin
        drain_ok = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (drain_count_in > lane_cnt[i]) drain_ok = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        flush_d  = flush_q;
        replay_d = replay_q;
        snap_en  = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q | wr_err;
        unique case (state_q)
            IDLE: begin
                if (drain_start_in) begin
                    if (drain_count_in == '0) begin
                        done_d = 1'b1;
                    end else if (!drain_ok) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d  = DRAIN;
                        rem_d    = drain_count_in;
                        replay_d = replay_in;
                        snap_en  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = FLUSH;
                    flush_d = LANE_W'(NUM_LANES - 1);
                end
            end
            FLUSH: begin
                flush_d = flush_q - LANE_W'(1);
                if (flush_q == LANE_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rd_stb[i]) data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_rd[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            flush_q     <= '0;
            replay_q    <= 1'b0;
            skew_stb_q  <= '0;
            skew_last_q <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            flush_q     <= flush_d;
            replay_q    <= replay_d;
            // Low strobes shifted up one stage is the skew shift itself.
            skew_stb_q  <= rd_stb[NUM_LANES-2:0];
            skew_last_q <= rd_last[NUM_LANES-2:0];
            data_q      <= data_d;
            valid_q     <= rd_stb;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        skew_lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (wr_data),
            .rd_en_i   (rd_stb[g]),
            .rd_last_i (rd_last[g]),
            .replay_i  (replay_q),
            .snap_en_i (snap_en),
            .rd_data_o (lane_rd[g]),
            .count_o   (lane_cnt[g]),
            .full_o    (full[g]),
            .empty_o   (empty[g])
        );
    end

    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign busy_out       = (state_q != IDLE);
    assign done_out       = done_q;
    assign err_out        = err_q;
    assign lane_full_out  = full;
    assign lane_empty_out = empty;

endmodule

// File: tb/tb_input_skew_buffer.sv
module tb_input_skew_buffer;
    localparam int DW = 16, NL = 4, DEPTH = 8, LW = 2, CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid_in = 1'b0;
    logic [LW-1:0] wr_lane_in = '0;
    logic [DW-1:0] wr_data_in = '0;
    logic          nn_valid_in = 1'b0;
    logic [LW-1:0] nn_lane_in = '0;
    logic [DW-1:0] nn_data_in = '0;
    logic          drain_start_in = 1'b0;
    logic [CW-1:0] drain_count_in = '0;
    logic          replay_in = 1'b0;
    logic          wr_ready_out;
    logic [NL*DW-1:0] data_out;
    logic [NL-1:0] valid_out;
    logic          busy_out, done_out, err_out;
    logic [NL-1:0] lane_full_out, lane_empty_out;

    always #5 clk = ~clk;

    input_skew_buffer #(.DATA_WIDTH(DW), .NUM_LANES(NL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid_in(wr_valid_in), .wr_lane_in(wr_lane_in), .wr_data_in(wr_data_in),
        .wr_ready_out(wr_ready_out),
        .nn_valid_in(nn_valid_in), .nn_lane_in(nn_lane_in), .nn_data_in(nn_data_in),
        .drain_start_in(drain_start_in), .drain_count_in(drain_count_in), .replay_in(replay_in),
        .data_out(data_out), .valid_out(valid_out), .busy_out(busy_out), .done_out(done_out),
        .lane_full_out(lane_full_out), .lane_empty_out(lane_empty_out), .err_out(err_out)
    );

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] lane_of(logic [NL*DW-1:0] v, int i);
        return v[i*DW +: DW];
    endfunction

    // ---------------- behavioural model ----------------
    // Each lane is a queue of values; a drain becomes a list of timed emissions.
    typedef struct {
        int            edge_n;
        logic [DW-1:0] d;
        bit            pop;
    } ev_t;

    logic [DW-1:0] mq  [NL][$];
    ev_t           evq [NL][$];
    int            e_cnt = 0;
    int            drain_end = -1;
    bit            busy_m = 0, done_m = 0, err_m = 0;
    logic [NL-1:0]    valid_m = '0;
    logic [NL*DW-1:0] data_m = '0;

    function automatic int min_size();
        int m = DEPTH;
        for (int i = 0; i < NL; i++) if (mq[i].size() < m) m = mq[i].size();
        return m;
    endfunction

    always @(posedge clk) begin : model
        int sz [NL];
        int minsz;
        int n;
        ev_t ev;
        e_cnt++;
        if (!rst) begin
            for (int i = 0; i < NL; i++) begin
                mq[i].delete();
                evq[i].delete();
            end
            drain_end = -1;
            busy_m = 0; done_m = 0; err_m = 0;
            valid_m = '0; data_m = '0;
        end else begin
            for (int i = 0; i < NL; i++) sz[i] = mq[i].size();
            minsz = min_size();
            done_m = 0;
            for (int i = 0; i < NL; i++) begin
                valid_m[i] = 1'b0;
                data_m[i*DW +: DW] = '0;
                if (evq[i].size() > 0 && evq[i][0].edge_n == e_cnt) begin
                    valid_m[i] = 1'b1;
                    data_m[i*DW +: DW] = evq[i][0].d;
                    if (evq[i][0].pop) void'(mq[i].pop_front());
                    void'(evq[i].pop_front());
                end
            end
            if (nn_valid_in) begin
                if (sz[nn_lane_in] == DEPTH) err_m = 1;
                else mq[nn_lane_in].push_back(nn_data_in);
            end else if (wr_valid_in) begin
                if (sz[wr_lane_in] == DEPTH) err_m = 1;
                else mq[wr_lane_in].push_back(wr_data_in);
            end
            if (drain_start_in && !busy_m) begin
                n = int'(drain_count_in);
                if (n == 0) done_m = 1;
                else if (n > minsz) begin
                    err_m = 1;
                    done_m = 1;
                end else begin
                    drain_end = e_cnt + n + NL - 1;
                    for (int i = 0; i < NL; i++)
                        for (int k = 0; k < n; k++) begin
                            ev.edge_n = e_cnt + 1 + i + k;
                            ev.d      = mq[i][k];
                            ev.pop    = !replay_in;
                            evq[i].push_back(ev);
                        end
                end
            end
            if (e_cnt == drain_end) done_m = 1;
            busy_m = (e_cnt < drain_end);
        end
    end

    always @(negedge clk) begin : cmp
        logic [NL-1:0] full_m, empty_m;
        #1;
        for (int i = 0; i < NL; i++) begin
            full_m[i]  = (mq[i].size() == DEPTH);
            empty_m[i] = (mq[i].size() == 0);
        end
        check("data_out",  data_out,  data_m);
        check("valid_out", valid_out, valid_m);
        check("busy_out",  busy_out,  busy_m);
        check("done_out",  done_out,  done_m);
        check("err_out",   err_out,   err_m);
        check("lane_full", lane_full_out, full_m);
        check("lane_empty", lane_empty_out, empty_m);
        check("wr_ready", wr_ready_out, !nn_valid_in && (mq[wr_lane_in].size() < DEPTH));
    end

    // ---------------- stimulus helpers ----------------
    task automatic at_neg(int k);
        repeat (k) @(negedge clk);
        #2;
    endtask

    task automatic write1(bit nn, int lane, int data);
        if (nn) begin
            nn_valid_in = 1'b1; nn_lane_in = LW'(lane); nn_data_in = DW'(data);
        end else begin
            wr_valid_in = 1'b1; wr_lane_in = LW'(lane); wr_data_in = DW'(data);
        end
        @(negedge clk);
        nn_valid_in = 1'b0;
        wr_valid_in = 1'b0;
    endtask

    task automatic start_drain(int n, bit rep);
        drain_start_in = 1'b1; drain_count_in = CW'(n); replay_in = rep;
        @(negedge clk);
        drain_start_in = 1'b0; drain_count_in = '0; replay_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_bound", busy_out, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_all(int per_lane);
        for (int l = 0; l < NL; l++)
            for (int k = 0; k < per_lane; k++) write1(0, l, (l + 1) * 10 + k);
    endtask

    task automatic check_skew_drain(string tag);
        at_neg(1);
        check({tag, "_l0r0"}, lane_of(data_out, 0), 16'd10);
        check({tag, "_v_T1"}, valid_out, 4'b0001);
        at_neg(1);
        check({tag, "_l0r1"}, lane_of(data_out, 0), 16'd11);
        at_neg(2);
        check({tag, "_l3r0"}, lane_of(data_out, 3), 16'd40);
        at_neg(1);
        check({tag, "_l3r1"}, lane_of(data_out, 3), 16'd41);
        check({tag, "_done"}, done_out, 1'b1);
        at_neg(1);
        check({tag, "_done_low"}, done_out, 1'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_empty", lane_empty_out, 4'hF);
        check("rst_full", lane_full_out, 4'h0);
        check("rst_err", err_out, 1'b0);

        for (int k = 0; k < 8; k++) write1(0, 2, k + 1);
        wr_lane_in = 2'd2;
        #2;
        check("fill_full", lane_full_out, 4'b0100);
        check("fill_ready", wr_ready_out, 1'b0);
        write1(1, 2, 99);
        #2;
        check("overflow_err", err_out, 1'b1);
        do_reset();

        load_all(2);
        start_drain(2, 0);
        check_skew_drain("consume");
        check("consume_empty", lane_empty_out, 4'hF);

        load_all(2);
        start_drain(2, 1);
        check_skew_drain("replay1");
        start_drain(2, 1);
        check_skew_drain("replay2");
        check("replay_not_empty", lane_empty_out, 4'h0);
        do_reset();

        write1(0, 0, 1); write1(0, 2, 1); write1(0, 3, 1);
        wr_valid_in = 1'b1; wr_lane_in = 2'd1; wr_data_in = 16'd5;
        nn_valid_in = 1'b1; nn_lane_in = 2'd1; nn_data_in = 16'hFFF9;
        #2;
        check("prio_ready", wr_ready_out, 1'b0);
        @(negedge clk);
        wr_valid_in = 1'b0; nn_valid_in = 1'b0;
        start_drain(1, 0);
        at_neg(2);
        check("prio_data", lane_of(data_out, 1), 16'hFFF9);
        wait_idle();
        check("prio_empty", lane_empty_out, 4'hF);
        do_reset();

        for (int k = 0; k < 7; k++) write1(0, 0, 100 + k);
        for (int l = 1; l < NL; l++) for (int k = 0; k < 4; k++) write1(1, l, 200 + k);
        start_drain(4, 0);
        for (int k = 0; k < 3; k++) write1(0, 0, 107 + k);
        wait_idle();
        for (int l = 1; l < NL; l++) for (int k = 0; k < 6; k++) write1(0, l, 300 + k);
        start_drain(7, 0);
        #2;
        check("wrap_reject7_err", err_out, 1'b1);
        check("wrap_reject7_done", done_out, 1'b1);
        start_drain(6, 0);
        at_neg(1);
        check("wrap_first", lane_of(data_out, 0), 16'd104);
        at_neg(5);
        check("wrap_last", lane_of(data_out, 0), 16'd109);
        wait_idle();
        check("wrap_empty", lane_empty_out, 4'hF);
        do_reset();

        load_all(2);
        start_drain(3, 0);
        #2;
        check("reject_err", err_out, 1'b1);
        check("reject_done", done_out, 1'b1);
        check("reject_valid", valid_out, 4'h0);
        do_reset();

        load_all(2);
        start_drain(2, 0);
        at_neg(1);
        check("mid_valid_pre", valid_out, 4'b0001);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_valid", valid_out, 4'h0);
        check("mid_rst_busy", busy_out, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            nn_valid_in    = ($urandom_range(0, 3) == 0);
            nn_lane_in     = LW'($urandom_range(0, NL - 1));
            nn_data_in     = DW'($urandom);
            wr_valid_in    = ($urandom_range(0, 1) == 0);
            wr_lane_in     = LW'($urandom_range(0, NL - 1));
            wr_data_in     = DW'($urandom);
            drain_start_in = ($urandom_range(0, 11) == 0);
            replay_in      = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) drain_count_in = CW'($urandom_range(0, 15));
            else drain_count_in = CW'($urandom_range(0, min_size()));
            if (c % 700 == 699) begin
                wr_valid_in = 1'b0; nn_valid_in = 1'b0; drain_start_in = 1'b0;
                do_reset();
            end else begin
                @(negedge clk);
            end
        end
        wr_valid_in = 1'b0; nn_valid_in = 1'b0; drain_start_in = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_skew_buffer.md
Name: input_skew_buffer

Overview:
Parametrised multi-lane input staging buffer that feeds the left edge of the systolic array. Each lane is an independent circular FIFO, written by the host loader or by the NN write-back path. On a drain command, the block emits a programmed number of rows with diagonal skew, so that lane i lags lane 0 by i cycles. A replay mode preserves the buffered data for reuse across weight tiles.

Parameters:
DATA_WIDTH, 16, signed element width
NUM_LANES, 4, number of lanes (systolic rows), must be at least 2
DEPTH, 8, entries per lane, power of two
LANE_W, $clog2(NUM_LANES), derived lane-index width
CNT_W, $clog2(DEPTH)+1, derived occupancy/count width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
wr_valid_in  in  1  host write strobe
wr_lane_in  in  LANE_W  host target lane
wr_data_in  in  DATA_WIDTH  host write data (signed)
wr_ready_out  out  1  combinational: !nn_valid_in && !lane_full_out[wr_lane_in]
nn_valid_in  in  1  NN write-back strobe; has priority over host
nn_lane_in  in  LANE_W  write-back target lane
nn_data_in  in  DATA_WIDTH  write-back data (signed)
drain_start_in  in  1  one-cycle drain command
drain_count_in  in  CNT_W  rows to emit, sampled with drain_start_in
replay_in  in  1  1 = keep data after drain; sampled with drain_start_in
data_out  out  NUM_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
valid_out  out  NUM_LANES  per-lane output valid
busy_out  out  1  high in DRAIN or FLUSH
done_out  out  1  one-cycle pulse at end of drain
lane_full_out  out  NUM_LANES  per-lane full flag
lane_empty_out  out  NUM_LANES  per-lane empty flag
err_out  out  1  sticky: overflow write or rejected drain

Behaviour:
- Reset (rst low, asynchronous): all pointers and counts go to 0, FSM goes to IDLE, and every output register is cleared (data_out=0, valid_out=0, busy_out=0, done_out=0, err_out=0). Memory contents are not required to clear. Reset mid-drain aborts the drain without emitting done_out.
- Writes:
  - The nn path writes when nn_valid_in=1 and the lane is not full.
  - The host path writes when wr_valid_in=1 and wr_ready_out=1.
  - Only one write occurs per cycle.
  - A host write while nn_valid_in=1 is dropped silently; the host must respect wr_ready_out.
  - A write to a full lane (either path) is dropped and sets err_out.
  - Writes are legal in every FSM state.
- Count rule: simultaneous write and drain-read on the same lane leaves count unchanged. In replay mode, drain reads never change count.
- FSM IDLE:
  - drain_start_in=1 with drain_count_in in 1..min(lane counts): latch N, latch the mode, snapshot the read pointers, and go to DRAIN.
  - drain_count_in greater than any lane's count: rejected; set err_out, pulse done_out next cycle, stay in IDLE.
  - drain_count_in=0: pulse done_out next cycle, no valids.
- FSM DRAIN:
  - Issue a lane-0 read strobe on each of N consecutive cycles.
  - A skew shift register (NUM_LANES-1 stages) delays the strobe to lane i by i cycles.
  - After N strobes, go to FLUSH.
- FSM FLUSH: wait NUM_LANES-1 cycles for the skew to empty, then go to IDLE and pulse done_out in that same cycle.
- drain_start_in is ignored while busy_out=1.
- Latency: with drain_start_in accepted at edge T, lane i row k appears on data_out with valid_out[i]=1 in the cycle after edge T+1+i+k. Output is registered; data_out of a lane is 0 whenever its valid is low.
- Consume mode: each lane's read pointer advances and its count decrements per read.
- Replay mode: each lane's read pointer is restored from the snapshot when its last read completes; counts are unchanged.
- Pointers wrap modulo DEPTH. full means count==DEPTH; empty means count==0.
- Data is stored and emitted unmodified; no arithmetic is performed.

Decomposition:
- Package tpu_buf_pkg: fsm_state_t enum (IDLE, DRAIN, FLUSH) and a DATA_WIDTH-default localparam.
- One sub-module, skew_lane_fifo: a single-lane circular FIFO (write port, read strobe, snapshot/restore, count/full/empty), instantiated NUM_LANES times via generate.
- The top level owns write arbitration, the FSM, the skew shift register and the output registers.

Test Plan:
- Reset/flags: after reset, lane_empty_out=4'hF, lane_full_out=0 and err_out=0. Writing 8 host values to lane 2 gives lane_full_out=4'b0100 and wr_ready_out=0 for lane 2; a 9th nn write sets err_out.
- Skewed drain: load lanes 0..3 with {10,11}, {20,21}, {30,31}, {40,41}, then drain N=2 in consume mode at T.
  - Lane 0 emits 10,11 at T+1,T+2.
  - Lane 3 emits 40,41 at T+4,T+5.
  - done_out pulses at T+5.
  - All lanes are empty afterwards.
- Replay: same load, drain N=2 with replay_in=1 twice. Both drains give identical output; counts stay 2; the lanes are not empty.
- Priority: wr_valid_in and nn_valid_in asserted in the same cycle, both to lane 1, with data 5 and -7. Only -7 is stored and wr_ready_out=0 that cycle.
- Concurrency and wrap: with DEPTH=8, fill lane 0 to 7 entries, drain 4 while writing 3 more. Pointers wrap, the final count is 6, and the data order is preserved (FIFO).
- Rejection and reset: drain_count_in=3 with a lane holding 2 entries gives err_out=1, a done_out pulse and no valids. Asserting rst mid-DRAIN clears valid_out and busy_out immediately (asynchronously), with no done_out.
